// File: rtl/fetch_unit.sv
// Bundle fetch stage: owns the fetch PC, issues in-order imem requests under a credit limit,
// buffers returned bundles in a small queue and presents one per cycle to decode.
module fetch_unit #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned FQ_DEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [31:0]           new_pc,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [32*SLOTS-1:0]   imem_rdata,
  output logic [32*SLOTS-1:0]   inst,
  output logic [31:0]           inst_pc,
  output logic                  inst_valid,
  output logic                  branch_squash
);

  localparam int unsigned PtrW   = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FQ_DEPTH + 1);
  localparam int unsigned BW     = 32 * SLOTS;
  localparam logic [31:0] PcStep = 32'(4 * SLOTS);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] pc_q, pc_d;
  logic        epoch_q, epoch_d;
  cnt_t        outst_q, outst_d;

  logic        tag_epoch_q [FQ_DEPTH];
  logic [31:0] tag_pc_q    [FQ_DEPTH];
  ptr_t        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [BW-1:0] fq_data_q [FQ_DEPTH];
  logic [31:0]   fq_pc_q   [FQ_DEPTH];
  ptr_t          fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
  cnt_t          fq_cnt_q, fq_cnt_d;

  logic            redirect, credit_ok, accept, resp, fq_push, fq_pop;
  logic [CntW:0]   in_use;

  always_comb begin
    redirect  = branch_taken && !stall;
    in_use    = {1'b0, outst_q} + {1'b0, fq_cnt_q};
    credit_ok = in_use < (CntW + 1)'(FQ_DEPTH);
    // imem_req is forced low while reset is held, not just by the cleared counters.
    imem_req  = rst && !redirect && credit_ok;
    accept    = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp      = imem_rvalid && (outst_q != '0);
    fq_push   = resp && (tag_epoch_q[tag_rd_q] == epoch_q) && !redirect;
    fq_pop    = inst_valid && !stall && !redirect;
  end

  always_comb begin
    pc_d     = pc_q;
    epoch_d  = epoch_q;
    outst_d  = outst_q;
    tag_rd_d = tag_rd_q;
    tag_wr_d = tag_wr_q;
    fq_rd_d  = fq_rd_q;
    fq_wr_d  = fq_wr_q;
    fq_cnt_d = fq_cnt_q;

    if (redirect) begin
      pc_d    = new_pc;
      epoch_d = !epoch_q;
    end else if (accept) begin
      pc_d = pc_q + PcStep;
    end

    if (accept) tag_wr_d = ptr_inc(tag_wr_q);
    if (resp)   tag_rd_d = ptr_inc(tag_rd_q);
    if (accept && !resp)      outst_d = outst_q + 1'b1;
    else if (!accept && resp) outst_d = outst_q - 1'b1;

    // Outstanding requests survive a redirect; their responses die on the epoch check.
    if (redirect) begin
      fq_rd_d  = '0;
      fq_wr_d  = '0;
      fq_cnt_d = '0;
    end else begin
      if (fq_push) fq_wr_d = ptr_inc(fq_wr_q);
      if (fq_pop)  fq_rd_d = ptr_inc(fq_rd_q);
      if (fq_push && !fq_pop)      fq_cnt_d = fq_cnt_q + 1'b1;
      else if (!fq_push && fq_pop) fq_cnt_d = fq_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      epoch_q  <= 1'b0;
      outst_q  <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
      fq_rd_q  <= '0;
      fq_wr_q  <= '0;
      fq_cnt_q <= '0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        tag_epoch_q[i] <= 1'b0;
        tag_pc_q[i]    <= '0;
        fq_data_q[i]   <= '0;
        fq_pc_q[i]     <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      epoch_q  <= epoch_d;
      outst_q  <= outst_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
      fq_rd_q  <= fq_rd_d;
      fq_wr_q  <= fq_wr_d;
      fq_cnt_q <= fq_cnt_d;
      if (accept) begin
        tag_epoch_q[tag_wr_q] <= epoch_q;
        tag_pc_q[tag_wr_q]    <= pc_q;
      end
      if (fq_push) begin
        fq_data_q[fq_wr_q] <= imem_rdata;
        fq_pc_q[fq_wr_q]   <= tag_pc_q[tag_rd_q];
      end
    end
  end

  always_comb begin
    imem_addr     = pc_q;
    branch_squash = branch_taken;
    inst_valid    = (fq_cnt_q != '0);
    inst          = {SLOTS{NOP_INST}};
    inst_pc       = '0;
    if (inst_valid) begin
      inst    = fq_data_q[fq_rd_q];
      inst_pc = fq_pc_q[fq_rd_q];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push hand-computed bundle PCs; a monitor
// pops and compares every bundle decode consumes. A small in-order imem model answers requests.
module tb_fetch_unit;

  localparam int unsigned SLOTS = 4;
  localparam int unsigned BW    = 32 * SLOTS;

  logic          clk, rst, stall, branch_taken, imem_gnt, imem_rvalid;
  logic [31:0]   new_pc, imem_addr, inst_pc;
  logic          imem_req, inst_valid, branch_squash;
  logic [BW-1:0] imem_rdata, inst;

  fetch_unit #(
    .SLOTS    (SLOTS),
    .FQ_DEPTH (2),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .new_pc        (new_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .branch_squash (branch_squash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_fail;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pend[$];

  int            lat, cyc;
  logic          model_rv, stray_rv;
  logic [BW-1:0] rdata_m, rdata_s;

  assign imem_rvalid = model_rv | stray_rv;
  assign imem_rdata  = model_rv ? rdata_m : rdata_s;

  function automatic logic [BW-1:0] mk(input logic [31:0] pc);
    logic [BW-1:0] r;
    for (int i = 0; i < int'(SLOTS); i++) r[32*i +: 32] = pc + 32'(4 * i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: the head pops at the next edge under exactly these conditions.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && inst_valid && !stall && !branch_taken && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("bundle_pc", inst_pc, e);
        chk("bundle_data", inst, mk(e));
      end
    end
  end

  // In-order imem: a request accepted at edge e answers in the cycle after edge e+lat-1.
  initial begin
    logic        s_rv, s_acc, hold_v;
    logic [31:0] s_addr, hold_addr;
    model_rv = 1'b0;
    rdata_m  = '0;
    cyc      = 0;
    hold_v   = 1'b0;
    hold_addr = '0;
    forever begin
      @(negedge clk);
      s_rv   = model_rv;
      s_acc  = rst && imem_req && imem_gnt;
      s_addr = imem_addr;
      if (hold_v && rst && imem_req) chk("addr_hold", imem_addr, hold_addr);
      hold_v    = rst && imem_req && !imem_gnt && !(branch_taken && !stall);
      hold_addr = imem_addr;
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        pend.delete();
      end else begin
        if (s_rv && pend.size() > 0) void'(pend.pop_front());
        if (s_acc) pend.push_back('{addr: s_addr, due: cyc + lat - 1});
      end
      model_rv = rst && pend.size() > 0 && pend[0].due <= cyc;
      rdata_m  = model_rv ? mk(pend[0].addr) : '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(16 * i));
  endtask

  task automatic do_reset(input int l);
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; new_pc = '0;
    imem_gnt = 1'b1; stray_rv = 1'b0;
    exp_q.delete();
    lat = l;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
    chk(name, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_pend(input int n);
    for (int i = 0; i < 50 && pend.size() != n; i++) begin
      step();
      #1;
    end
    chk("pend_reached", 32'(pend.size()), 32'(n));
  endtask

  initial begin
    logic [BW-1:0] cap_inst;
    logic [31:0]   cap_pc, a0;
    n_vec = 0; n_fail = 0;
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; new_pc = '0;
    imem_gnt = 1'b1; stray_rv = 1'b0; rdata_s = '0; lat = 1;

    // Reset state, then a free-running stream with a 1-cycle imem.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_squash_lo", branch_squash, 0);
    branch_taken = 1'b1;
    #1 chk("rst_squash_hi", branch_squash, 1);
    branch_taken = 1'b0;
    step();
    rst = 1'b1;
    push_seq(32'h0, 8);
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", inst_valid, 0);
    step();
    @(negedge clk);
    chk("no_comb_rdata_path", inst_valid, 0);
    wait_drain("drain_stream", 100);

    // Five-cycle stall mid-stream.
    do_reset(1);
    push_seq(32'h0, 10);
    for (int i = 0; i < 50 && exp_q.size() > 7; i++) step();
    stall = 1'b1;
    step();
    step();
    @(negedge clk);
    cap_inst = inst;
    cap_pc   = inst_pc;
    chk("stall_valid", inst_valid, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      chk("stall_inst_stable", inst, cap_inst);
      chk("stall_pc_stable", inst_pc, cap_pc);
      chk("stall_req_low", imem_req, 0);
    end
    step();
    stall = 1'b0;
    wait_drain("drain_stall", 100);

    // Redirect to 0x400 with two requests in flight on a 3-cycle imem.
    do_reset(3);
    push_seq(32'h400, 3);
    wait_pend(2);
    branch_taken = 1'b1;
    new_pc = 32'h400;
    @(negedge clk);
    chk("redir_squash", branch_squash, 1);
    chk("redir_req_low", imem_req, 0);
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("redir_addr", imem_addr, 32'h400);
    chk("redir_flushed", inst_valid, 0);
    wait_drain("drain_redirect", 100);

    // Branch held three cycles, stalled for the first two: acts once, at the third edge.
    do_reset(3);
    push_seq(32'h0, 2);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    imem_gnt = 1'b0;
    stall = 1'b1;
    branch_taken = 1'b1;
    new_pc = 32'h800;
    push_seq(32'h800, 3);
    @(negedge clk);
    chk("sbr_squash0", branch_squash, 1);
    a0 = imem_addr;
    step();
    @(negedge clk);
    chk("sbr_squash1", branch_squash, 1);
    chk("sbr_addr1", imem_addr, a0);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("sbr_squash2", branch_squash, 1);
    chk("sbr_addr2", imem_addr, a0);
    chk("sbr_req_low", imem_req, 0);
    step();
    branch_taken = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    chk("sbr_addr3", imem_addr, 32'h800);
    wait_drain("drain_stall_branch", 100);

    // Random 50% grant on a 2-cycle imem.
    do_reset(2);
    push_seq(32'h0, 10);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      step();
      imem_gnt = 1'($urandom_range(0, 1));
    end
    imem_gnt = 1'b1;
    wait_drain("drain_gnt", 100);

    // Reset with two outstanding, then a stray response with nothing outstanding.
    do_reset(3);
    wait_pend(2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", inst_valid, 0);
    chk("mrst_req", imem_req, 0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_inst_pc", inst_pc, 0);
    imem_gnt = 1'b0;
    step();
    step();
    rst = 1'b1;
    stray_rv = 1'b1;
    rdata_s = mk(32'h0);
    @(negedge clk);
    chk("stray_req", imem_req, 1);
    chk("stray_addr", imem_addr, 32'h0);
    step();
    stray_rv = 1'b0;
    @(negedge clk);
    chk("stray_ignored_valid", inst_valid, 0);
    chk("stray_ignored_req", imem_req, 1);
    chk("stray_ignored_addr", imem_addr, 32'h0);
    push_seq(32'h0, 2);
    step();
    imem_gnt = 1'b1;
    wait_drain("drain_mid_reset", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
